// File: rtl/mem_access_adaptor.sv
// Responder side of the memory-operator access-task interface: serialises one
// load/store task into byte accesses on the byte-wide RAM/IO bus.
module mem_access_adaptor #(
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        have_mem_access_task,
    input  logic [31:0] mem_access_addr,
    input  logic        mem_access_rw,
    input  logic [1:0]  mem_access_size,
    input  logic [31:0] mem_access_data,
    output logic        mem_access_task_done,
    output logic [31:0] mem_access_data_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RD_TAIL = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        rw_q;
    logic [1:0]  last_q;
    logic [1:0]  k_q;
    logic [31:0] mem_a_q;
    logic [7:0]  dout_q;
    logic        wr_q;
    logic        done_q;
    logic [31:0] data_out_q;
    logic        flushed_q;
    logic        cap_valid_q;
    logic [1:0]  cap_idx_q;

    logic [1:0]  next_k_d;
    logic [31:0] next_a_d;
    logic        cur_issued_d;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] byte_put(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        byte_put = r;
    endfunction

    function automatic logic [1:0] size_to_last(input logic [1:0] size);
        case (size)
            2'b00:   size_to_last = 2'd0;
            2'b01:   size_to_last = 2'd1;
            default: size_to_last = 2'd3;
        endcase
    endfunction

    function automatic logic io_stall(input logic [31:0] a, input logic full);
        io_stall = (a[17:16] == IO_ADDR_HI) && full;
    endfunction

    // Next byte address/index and whether the byte on the bus this cycle really went out.
    always_comb begin
        next_k_d = k_q + 2'd1;
        next_a_d = addr_q + {30'd0, next_k_d};
        if (rw_q) begin
            cur_issued_d = wr_q;
        end else begin
            cur_issued_d = 1'b1;
        end
    end

    // Task FSM; rdy_in low freezes every register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            rw_q        <= 1'b0;
            last_q      <= 2'd0;
            k_q         <= 2'd0;
            mem_a_q     <= 32'd0;
            dout_q      <= 8'd0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= 32'd0;
            flushed_q   <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= 2'd0;
        end else if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    done_q      <= 1'b0;
                    wr_q        <= 1'b0;
                    cap_valid_q <= 1'b0;
                    if (have_mem_access_task && !flush_pipline) begin
                        addr_q     <= mem_access_addr;
                        data_q     <= mem_access_data;
                        rw_q       <= mem_access_rw;
                        last_q     <= size_to_last(mem_access_size);
                        k_q        <= 2'd0;
                        flushed_q  <= 1'b0;
                        data_out_q <= 32'd0;
                        mem_a_q    <= mem_access_addr;
                        wr_q       <= mem_access_rw && !io_stall(mem_access_addr, io_buffer_full);
                        dout_q     <= mem_access_rw ? mem_access_data[7:0] : 8'd0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!rw_q && flush_pipline) begin
                        state_q     <= IDLE;
                        wr_q        <= 1'b0;
                        cap_valid_q <= 1'b0;
                    end else begin
                        if (cap_valid_q) begin
                            data_out_q <= byte_put(data_out_q, cap_idx_q, mem_din);
                        end
                        // A flushed store still finishes so memory never sees a torn write.
                        if (flush_pipline) begin
                            flushed_q <= 1'b1;
                        end
                        cap_valid_q <= 1'b0;
                        if (cur_issued_d) begin
                            if (!rw_q) begin
                                cap_valid_q <= 1'b1;
                                cap_idx_q   <= k_q;
                            end
                            if (k_q == last_q) begin
                                wr_q   <= 1'b0;
                                dout_q <= 8'd0;
                                if (!rw_q) begin
                                    state_q <= RD_TAIL;
                                end else if (flushed_q || flush_pipline) begin
                                    state_q <= IDLE;
                                end else begin
                                    state_q <= DONE;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                k_q     <= next_k_d;
                                mem_a_q <= next_a_d;
                                dout_q  <= rw_q ? byte_sel(data_q, next_k_d) : 8'd0;
                                wr_q    <= rw_q && !io_stall(next_a_d, io_buffer_full);
                            end
                        end else begin
                            wr_q <= !io_stall(mem_a_q, io_buffer_full);
                        end
                    end
                end
                RD_TAIL: begin
                    cap_valid_q <= 1'b0;
                    if (flush_pipline) begin
                        state_q <= IDLE;
                    end else begin
                        if (cap_valid_q) begin
                            data_out_q <= byte_put(data_out_q, cap_idx_q, mem_din);
                        end
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    wr_q    <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_a                = mem_a_q;
    assign mem_dout             = dout_q;
    assign mem_wr               = wr_q & rdy_in;
    assign mem_access_task_done = done_q;
    assign mem_access_data_out  = data_out_q;

endmodule

// File: tb/tb_mem_access_adaptor.sv
// Directed and randomized bench for mem_access_adaptor with a byte RAM model that
// pauses together with rdy_in, plus a step-count reference model for latency.
`timescale 1ns/1ps
module tb_mem_access_adaptor;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_pipline;
    logic        have_mem_access_task;
    logic [31:0] mem_access_addr;
    logic        mem_access_rw;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_access_data;
    logic        mem_access_task_done;
    logic [31:0] mem_access_data_out;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] wlog_a [$];
    logic [7:0]  wlog_d [$];

    always #5 clk_in = ~clk_in;

    mem_access_adaptor #(.IO_ADDR_HI(2'b11)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .rdy_in               (rdy_in),
        .flush_pipline        (flush_pipline),
        .have_mem_access_task (have_mem_access_task),
        .mem_access_addr      (mem_access_addr),
        .mem_access_rw        (mem_access_rw),
        .mem_access_size      (mem_access_size),
        .mem_access_data      (mem_access_data),
        .mem_access_task_done (mem_access_task_done),
        .mem_access_data_out  (mem_access_data_out),
        .mem_din              (mem_din),
        .mem_dout             (mem_dout),
        .mem_a                (mem_a),
        .mem_wr               (mem_wr),
        .io_buffer_full       (io_buffer_full)
    );

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Ends the current cycle: the RAM takes the write and, when ready, returns the addressed byte.
    task automatic next_cycle();
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;
        logic        r;
        a = mem_a;
        w = mem_wr;
        d = mem_dout;
        r = rdy_in;
        @(posedge clk_in);
        #1;
        if (w) begin
            ram[a] = d;
            wlog_a.push_back(a);
            wlog_d.push_back(d);
        end
        if (r) mem_din = rd(a);
        cyc++;
    endtask

    task automatic idle_inputs();
        have_mem_access_task = 1'b0;
        mem_access_addr      = 32'd0;
        mem_access_rw        = 1'b0;
        mem_access_size      = 2'b00;
        mem_access_data      = 32'd0;
        flush_pipline        = 1'b0;
        io_buffer_full       = 1'b0;
        rdy_in               = 1'b1;
    endtask

    task automatic set_task(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                            input logic [31:0] d);
        have_mem_access_task = 1'b1;
        mem_access_addr      = a;
        mem_access_rw        = rw;
        mem_access_size      = sz;
        mem_access_data      = d;
    endtask

    // Reference: the adaptor advances one step per ready cycle; the pulse is up while
    // exactly lat ready cycles (the accept cycle included) have elapsed.
    task automatic run_task(input logic [31:0] a, input logic rw, input logic [1:0] sz,
                            input logic [31:0] d, input bit pauses);
        int          n;
        int          lat;
        int          hi;
        bit          fin;
        logic [31:0] exp_out;
        n   = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        lat = rw ? n + 1 : n + 2;
        exp_out = 32'd0;
        for (int k = 0; k < n; k++) exp_out = exp_out | (32'(rd(a + 32'(k))) << (8 * k));
        wlog_a.delete();
        wlog_d.delete();
        next_cycle();
        set_task(a, rw, sz, d);
        rdy_in         = 1'b1;
        flush_pipline  = 1'b0;
        io_buffer_full = 1'($urandom_range(0, 1));
        #1;
        hi  = 1;
        fin = 1'b0;
        for (int t = 1; t <= 40 && !fin; t++) begin
            next_cycle();
            rdy_in         = pauses ? ($urandom_range(0, 3) != 0) : 1'b1;
            io_buffer_full = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_done", 32'(mem_access_task_done), 32'(hi == lat));
            if (hi == lat && !rw) chk("rnd_data", mem_access_data_out, exp_out);
            if (hi == lat && rdy_in) fin = 1'b1;
            if (rdy_in) hi++;
        end
        chk("rnd_finished", 32'(fin), 32'd1);
        chk("rnd_nwrites", 32'(wlog_a.size()), rw ? 32'(n) : 32'd0);
        foreach (wlog_a[i]) begin
            chk("rnd_waddr", wlog_a[i], a + 32'(i));
            chk("rnd_wdata", 32'(wlog_d[i]), 32'(8'(d >> (8 * i))));
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic        rrw;
        logic [1:0]  rsz;

        rst_in  = 1'b1;
        mem_din = 8'h00;
        idle_inputs();
        next_cycle();
        next_cycle();
        #1;
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_done", 32'(mem_access_task_done), 32'd0);
        chk("rst_data_out", mem_access_data_out, 32'd0);
        rst_in = 1'b0;

        // lw @0x1000 over bytes 11 22 33 44
        ram[32'h1000] = 8'h11;
        ram[32'h1001] = 8'h22;
        ram[32'h1002] = 8'h33;
        ram[32'h1003] = 8'h44;
        next_cycle();
        set_task(32'h1000, 1'b0, 2'b10, 32'd0);
        #1;
        for (int t = 1; t <= 6; t++) begin
            next_cycle();
            #1;
            if (t <= 4) chk("lw_addr", mem_a, 32'h1000 + 32'(t - 1));
            chk("lw_wr", 32'(mem_wr), 32'd0);
            chk("lw_done", 32'(mem_access_task_done), 32'(t == 6));
        end
        chk("lw_data", mem_access_data_out, 32'h44332211);

        // sh @0x2002, accepted in the cycle right after the previous pulse
        wlog_a.delete();
        wlog_d.delete();
        next_cycle();
        set_task(32'h2002, 1'b1, 2'b01, 32'hDEADBEEF);
        #1;
        next_cycle();
        #1;
        chk("sh_a0", mem_a, 32'h2002);
        chk("sh_wr0", 32'(mem_wr), 32'd1);
        chk("sh_d0", 32'(mem_dout), 32'hEF);
        chk("sh_done1", 32'(mem_access_task_done), 32'd0);
        next_cycle();
        #1;
        chk("sh_a1", mem_a, 32'h2003);
        chk("sh_wr1", 32'(mem_wr), 32'd1);
        chk("sh_d1", 32'(mem_dout), 32'hBE);
        next_cycle();
        #1;
        chk("sh_wr_end", 32'(mem_wr), 32'd0);
        chk("sh_done3", 32'(mem_access_task_done), 32'd1);

        // sb into IO space; the full flag is seen in each cycle a stalled byte is prepared
        next_cycle();
        set_task(32'h0003_0000, 1'b1, 2'b00, 32'h0000_0041);
        io_buffer_full = 1'b1;
        #1;
        for (int t = 1; t <= 5; t++) begin
            next_cycle();
            io_buffer_full = (t <= 2);
            #1;
            chk("io_wr", 32'(mem_wr), 32'(t == 4));
            chk("io_done", 32'(mem_access_task_done), 32'(t == 5));
            if (t == 4) chk("io_dout", 32'(mem_dout), 32'h41);
            if (t == 4) chk("io_addr", mem_a, 32'h0003_0000);
        end
        chk("sh_sb_nwrites", 32'(wlog_a.size()), 32'd3);
        chk("sh_no_2004", 32'(ram.exists(32'h2004)), 32'd0);
        chk("sh_ram2003", 32'(ram[32'h2003]), 32'hBE);

        // lb of 0x80: zero filled, no sign extension
        ram[32'h80] = 8'h80;
        next_cycle();
        set_task(32'h80, 1'b0, 2'b00, 32'd0);
        io_buffer_full = 1'b0;
        #1;
        for (int t = 1; t <= 3; t++) begin
            next_cycle();
            #1;
            chk("lb_done", 32'(mem_access_task_done), 32'(t == 3));
        end
        chk("lb_data", mem_access_data_out, 32'h0000_0080);

        // lw flushed in cycle 2, then a fresh sb in cycle 3
        next_cycle();
        set_task(32'h1000, 1'b0, 2'b10, 32'd0);
        #1;
        for (int t = 1; t <= 8; t++) begin
            next_cycle();
            flush_pipline = (t == 2);
            if (t == 3) set_task(32'h40, 1'b1, 2'b00, 32'h0000_005A);
            if (t == 6) have_mem_access_task = 1'b0;
            #1;
            chk("fl_done", 32'(mem_access_task_done), 32'(t == 5));
            chk("fl_wr", 32'(mem_wr), 32'(t == 4));
            if (t == 4) chk("fl_addr", mem_a, 32'h40);
            if (t == 4) chk("fl_dout", 32'(mem_dout), 32'h5A);
        end

        // lw with rdy_in low in cycles 2-3
        next_cycle();
        set_task(32'h1000, 1'b0, 2'b10, 32'd0);
        #1;
        for (int t = 1; t <= 8; t++) begin
            next_cycle();
            rdy_in = !(t == 2 || t == 3);
            #1;
            chk("rdy_wr", 32'(mem_wr), 32'd0);
            chk("rdy_done", 32'(mem_access_task_done), 32'(t == 8));
            if (t >= 2 && t <= 4) chk("rdy_addr_hold", mem_a, 32'h1001);
        end
        chk("rdy_data", mem_access_data_out, 32'h44332211);

        // reset in the middle of a sw
        wlog_a.delete();
        wlog_d.delete();
        next_cycle();
        set_task(32'h5000, 1'b1, 2'b10, 32'h01020304);
        #1;
        next_cycle();
        #1;
        chk("rs_wr1", 32'(mem_wr), 32'd1);
        chk("rs_d1", 32'(mem_dout), 32'h04);
        next_cycle();
        rst_in = 1'b1;
        #1;
        next_cycle();
        rst_in = 1'b0;
        have_mem_access_task = 1'b0;
        #1;
        chk("rs_bus_idle", 32'(mem_wr), 32'd0);
        chk("rs_addr", mem_a, 32'd0);
        for (int t = 0; t < 4; t++) begin
            next_cycle();
            #1;
            chk("rs_no_done", 32'(mem_access_task_done), 32'd0);
            chk("rs_no_wr", 32'(mem_wr), 32'd0);
        end
        chk("rs_nwrites", 32'(wlog_a.size()), 32'd2);

        // randomized back-to-back tasks, half of them with random ready pauses
        for (int i = 0; i < 40; i++) begin
            rrw = 1'($urandom_range(0, 1));
            rsz = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if (rrw) begin
                ra[17:16] = 2'($urandom_range(0, 2));
                if (ra[15:0] > 16'hFFF0) ra[15:0] = 16'h1000;
            end else if ($urandom_range(0, 3) == 0) begin
                ra[17:16] = 2'b11;
            end
            run_task(ra, rrw, rsz, $urandom, (i % 2) == 1);
        end
        next_cycle();
        idle_inputs();
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
